// File: rtl/audio_ctrl_pkg.sv
// Shared sample-pair type and mute/attenuation helper for audio_stream_ctrl.
package audio_ctrl_pkg;

  localparam int AUDIO_DATA_W = 24;
  // Working width for attenuation; callers sign-extend into it and truncate back.
  localparam int PROC_W       = 64;

  typedef struct packed {
    logic [AUDIO_DATA_W-1:0] left;
    logic [AUDIO_DATA_W-1:0] right;
  } pair_t;

  function automatic logic [PROC_W-1:0] mute_atten(
    input logic signed [PROC_W-1:0] s,
    input logic                     mute,
    input logic [2:0]               shift
  );
    if (mute) return '0;
    return s >>> shift;
  endfunction

endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous show-ahead FIFO of sample pairs with flush and level output.
module audio_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/audio_stream_ctrl.sv
// CODEC capture->playback sequencer: pair FIFO, mute/attenuation, output register.
// Optional test-tone source selected by src_sel when AUDIO_NOISE_SRC_EN is defined.
module audio_stream_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     read_ready,
  input  logic [DATA_W-1:0]        readdata_left,
  input  logic [DATA_W-1:0]        readdata_right,
  input  logic                     write_ready,
  input  logic                     mute,
  input  logic [2:0]               vol_shift,
`ifdef AUDIO_NOISE_SRC_EN
  input  logic                     src_sel,
`endif
  output logic                     read,
  output logic                     write,
  output logic [DATA_W-1:0]        writedata_left,
  output logic [DATA_W-1:0]        writedata_right,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overrun,
  output logic [CNT_W-1:0]         pair_count
);
  localparam int PW = 2*DATA_W;

  logic [1:0][DATA_W-1:0] push_data, fifo_head, head, proc, wdata;
  logic full, empty, out_valid, avail, load, fifo_push, fifo_pop;

  assign read  = reset_n & enable & read_ready & ~full;
  assign write = reset_n & enable & write_ready & out_valid;

  // An empty FIFO falls through so a freshly popped pair reaches the
  // output register on the next edge (1-clk latency, 1 pair/clk streaming).
  assign avail     = ~empty | read;
  assign load      = enable & avail & (~out_valid | write);
  assign head      = empty ? push_data : fifo_head;
  assign fifo_push = read & ~(empty & load);
  assign fifo_pop  = load & ~empty;

`ifdef AUDIO_NOISE_SRC_EN
  logic [2:0]        noise_c;
  logic [DATA_W-1:0] noise_s;
  assign noise_s   = {{(DATA_W-14){noise_c[2]}}, noise_c, 11'd0};
  assign push_data = src_sel ? {noise_s, noise_s} : {readdata_left, readdata_right};
  always_ff @(posedge clk)
    if (!reset_n)            noise_c <= '0;
    else if (read && src_sel) noise_c <= noise_c + 3'd1;
`else
  assign push_data = {readdata_left, readdata_right};
`endif

  audio_pair_fifo #(.DEPTH(DEPTH), .W(PW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (~enable),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (push_data),
    .dout    (fifo_head),
    .level   (fifo_level),
    .full    (full),
    .empty   (empty)
  );

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    assign proc[ch] = DATA_W'(mute_atten({{(PROC_W-DATA_W){head[ch][DATA_W-1]}}, head[ch]},
                                         mute, vol_shift));
  end

  // mute/vol_shift only take effect here, at load time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      wdata     <= '0;
    end else if (!enable) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      wdata     <= proc;
    end else if (write) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun    <= 1'b0;
      pair_count <= '0;
    end else begin
      if (enable && read_ready && full) overrun <= 1'b1;
      if (write) pair_count <= pair_count + 1'b1;
    end
  end

  assign writedata_left  = wdata[1];
  assign writedata_right = wdata[0];

endmodule
